// File: rtl/pll_rst_pkg.sv
// rtl/pll_rst_pkg.sv - shared types and sizing helpers for the PLL reset sequencer
package pll_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    // One shared counter serves both lock qualification and stage spacing,
    // so it is sized for the larger of the two intervals.
    function automatic int cnt_width(input int lock_cycles, input int stage_delay);
        int m;
        m = (lock_cycles > stage_delay) ? lock_cycles : stage_delay;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - multi-flop synchronizer for a single asynchronous status bit
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the flop chain; clears to 0 on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - qualifies PLL lock and releases domain resets in order
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_DELAY        = 16,
    parameter int NUM_STAGES         = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  soft_reset_req,
    output logic [NUM_STAGES-1:0] reset_out,
    output logic                  ready,
    output logic [7:0]            lock_lost_count
);

    localparam int CNT_W = cnt_width(LOCK_STABLE_CYCLES, STAGE_DELAY);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_STAGES - 1);

    logic                  locked_s;
    seq_state_t            state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [IDX_W-1:0]      idx, idx_n;
    logic [NUM_STAGES-1:0] reset_out_n;
    logic                  ready_n;
    logic [7:0]            lock_lost_count_n;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (pll_locked),
        .dout (locked_s)
    );

    // State and all outputs are registered here; nothing reaches a port combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= WAIT_LOCK;
            cnt             <= '0;
            idx             <= '0;
            reset_out       <= '1;
            ready           <= 1'b0;
            lock_lost_count <= 8'd0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            idx             <= idx_n;
            reset_out       <= reset_out_n;
            ready           <= ready_n;
            lock_lost_count <= lock_lost_count_n;
        end
    end

    // Next-state logic: lock loss beats soft reset, which beats normal progression.
    always_comb begin
        state_n           = state;
        cnt_n             = cnt;
        idx_n             = idx;
        reset_out_n       = reset_out;
        ready_n           = ready;
        lock_lost_count_n = lock_lost_count;

        if (state != WAIT_LOCK && !locked_s) begin
            state_n     = WAIT_LOCK;
            cnt_n       = '0;
            idx_n       = '0;
            reset_out_n = '1;
            ready_n     = 1'b0;
            if (lock_lost_count != 8'hFF) begin
                lock_lost_count_n = lock_lost_count + 8'd1;
            end
        end else if (soft_reset_req && (state == RELEASE || state == RUN)) begin
            state_n     = HOLD;
            cnt_n       = '0;
            idx_n       = '0;
            reset_out_n = '1;
            ready_n     = 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (!locked_s) begin
                        cnt_n = '0;
                    end else if (cnt == LOCK_LAST) begin
                        state_n = RELEASE;
                        cnt_n   = '0;
                        idx_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                HOLD: begin
                    // Lock never dropped, so only the spacing delay is re-applied.
                    if (cnt == STAGE_LAST) begin
                        state_n = RELEASE;
                        cnt_n   = '0;
                        idx_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt == STAGE_LAST) begin
                        reset_out_n[idx] = 1'b0;
                        cnt_n            = '0;
                        if (idx == IDX_LAST) begin
                            state_n = RUN;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                RUN: begin
                    // ready trails the final release by one edge.
                    reset_out_n = '0;
                    ready_n     = 1'b1;
                end
                default: begin
                    state_n     = WAIT_LOCK;
                    cnt_n       = '0;
                    idx_n       = '0;
                    reset_out_n = '1;
                    ready_n     = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    localparam int LSC = 8;
    localparam int SD  = 4;
    localparam int NS  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          pll_locked;
    logic          soft_reset_req;
    logic [NS-1:0] reset_out;
    logic          ready;
    logic [7:0]    lock_lost_count;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (LSC),
        .STAGE_DELAY        (SD),
        .NUM_STAGES         (NS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pll_locked      (pll_locked),
        .soft_reset_req  (soft_reset_req),
        .reset_out       (reset_out),
        .ready           (ready),
        .lock_lost_count (lock_lost_count)
    );

    always #5 clk = ~clk;

    // Model: lock seen two edges late; once qualified, "age" counts edges since
    // release began and the outputs follow from age by arithmetic.
    bit            m_s0, m_s1, m_ls;
    bit            m_active;
    bit            m_valid = 1'b0;
    int            m_run, m_age, m_llc, m_rel;
    logic [NS-1:0] m_rst;
    logic          m_ready;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_s0 = 1'b0; m_s1 = 1'b0; m_active = 1'b0;
            m_run = 0; m_age = 0; m_llc = 0; m_valid = 1'b1;
        end else begin
            m_ls = m_s1;
            m_s1 = m_s0;
            m_s0 = pll_locked;
            if (!m_active) begin
                if (m_ls) begin
                    m_run++;
                    if (m_run == LSC) begin
                        m_active = 1'b1; m_age = 0; m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else if (!m_ls) begin
                m_active = 1'b0; m_run = 0;
                if (m_llc < 255) m_llc++;
            end else if (soft_reset_req && m_age >= 0) begin
                m_age = -SD;
            end else begin
                m_age++;
            end
        end
        if (!m_active) begin
            m_rst = '1; m_ready = 1'b0;
        end else begin
            m_rel = (m_age <= 0) ? 0 : m_age / SD;
            if (m_rel > NS) m_rel = NS;
            for (int k = 0; k < NS; k++) m_rst[k] = (k >= m_rel);
            m_ready = (m_age >= SD * NS + 1);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            total++;
            if (reset_out === m_rst && ready === m_ready && lock_lost_count === 8'(m_llc)) begin
                passed++;
            end else begin
                $display("FAIL model cyc=%0d: got rst=%b rdy=%b cnt=%0d expected rst=%b rdy=%b cnt=%0d",
                         cyc, reset_out, ready, lock_lost_count, m_rst, m_ready, m_llc);
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // kind 0: reset_out[b] low; 1: ready high; 2: all resets asserted
    task automatic wait_for(input int kind, input int b, output int e);
        e = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((kind == 0 && reset_out[b] == 1'b0) || (kind == 1 && ready == 1'b1) ||
                (kind == 2 && reset_out == 3'b111)) begin
                e = cyc;
                break;
            end
        end
    endtask

    int t, e;

    initial begin
        rst = 1'b1; pll_locked = 1'b0; soft_reset_req = 1'b0;
        repeat (3) @(negedge clk);
        check("por_reset_out", int'(reset_out), 7);
        check("por_ready", int'(ready), 0);
        check("por_count", int'(lock_lost_count), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("por_hold_reset_out", int'(reset_out), 7);
        check("por_hold_ready", int'(ready), 0);

        pll_locked = 1'b1; t = cyc + 1;
        wait_for(0, 0, e); check("clean_rel0", e - t, 13);
        wait_for(0, 1, e); check("clean_rel1", e - t, 17);
        wait_for(0, 2, e); check("clean_rel2", e - t, 21);
        wait_for(1, 0, e); check("clean_ready", e - t, 22);
        repeat (3) @(negedge clk);

        pll_locked = 1'b0; t = cyc + 1;
        wait_for(2, 0, e); check("loss_latency", e - t, 2);
        check("loss_ready", int'(ready), 0);
        check("loss_count", int'(lock_lost_count), 1);
        repeat (5) @(negedge clk);
        pll_locked = 1'b1; t = cyc + 1;
        wait_for(0, 0, e); check("relock_rel0", e - t, 13);
        wait_for(1, 0, e); check("relock_ready", e - t, 22);
        repeat (3) @(negedge clk);

        soft_reset_req = 1'b1; t = cyc + 1;
        @(negedge clk);
        soft_reset_req = 1'b0;
        check("soft_assert", int'(reset_out), 7);
        check("soft_ready_low", int'(ready), 0);
        wait_for(0, 0, e); check("soft_rel0", e - t, 8);
        wait_for(1, 0, e); check("soft_ready", e - t, 17);
        check("soft_count", int'(lock_lost_count), 1);

        pll_locked = 1'b0;
        repeat (10) @(negedge clk);
        pll_locked = 1'b1;
        repeat (5) @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1; t = cyc + 1;
        wait_for(0, 0, e); check("glitch_rel0", e - t, 13);
        wait_for(1, 0, e); check("glitch_ready", e - t, 22);
        check("glitch_count", int'(lock_lost_count), 2);
        repeat (3) @(negedge clk);

        pll_locked = 1'b0;
        @(negedge clk);
        @(negedge clk);
        soft_reset_req = 1'b1;
        @(negedge clk);
        soft_reset_req = 1'b0;
        check("simul_reset_out", int'(reset_out), 7);
        check("simul_count", int'(lock_lost_count), 3);
        repeat (20) @(negedge clk);
        check("simul_no_hold", int'(reset_out), 7);

        for (int n = 0; n < 260; n++) begin
            pll_locked = 1'b1;
            repeat (12) @(negedge clk);
            pll_locked = 1'b0;
            repeat (4) @(negedge clk);
        end
        check("saturate_count", int'(lock_lost_count), 255);

        rst = 1'b1;
        @(negedge clk);
        check("rerst_count", int'(lock_lost_count), 0);
        check("rerst_reset_out", int'(reset_out), 7);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Consumer end of the PLL `locked` output, running in the 40 MHz system clock domain.
- Synchronizes the asynchronous `locked` signal and requires it to be stable before releasing anything.
- Releases per-domain resets in order (memory/bus, CPU, peripherals) with fixed spacing, then asserts `ready`.
- On loss of lock or a soft-reset request, re-asserts all resets at once and restarts the sequence.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops on `pll_locked` (≥2).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before release begins (≥2).
- STAGE_DELAY, 16: cycles between successive reset releases (≥2).
- NUM_STAGES, 3: number of sequenced reset outputs (1..8).

Ports:
- clk  in  1  system clock (PLL outclk_0).
- rst  in  1  synchronous active-high reset.
- pll_locked  in  1  raw PLL lock; asynchronous to clk.
- soft_reset_req  in  1  single-cycle synchronous request to re-run the release sequence.
- reset_out  out  NUM_STAGES  active-high domain resets; bit 0 is released first.
- ready  out  1  high when all domains are out of reset.
- lock_lost_count  out  8  count of lock-loss events; saturates at 255.

Behaviour:
- Reset values (rst high at an edge): reset_out all 1; ready 0; lock_lost_count 0; synchronizer flops 0; counters 0; state WAIT_LOCK.
- locked_s is the output of the SYNC_STAGES flop chain. All decisions use locked_s only.
- States: WAIT_LOCK, HOLD, RELEASE, RUN.
- WAIT_LOCK:
  - Stable counter increments each edge while locked_s=1 and clears when locked_s=0.
  - At the edge where cnt==LOCK_STABLE_CYCLES-1 and locked_s=1: go to RELEASE, clear cnt.
  - soft_reset_req is ignored.
- RELEASE:
  - stage index i starts at 0; cnt counts 0..STAGE_DELAY-1.
  - At the edge where cnt==STAGE_DELAY-1: reset_out[i] goes to 0, i increments, cnt clears.
  - After reset_out[NUM_STAGES-1] clears: go to RUN. ready rises on the following edge, so ready lags the last release by exactly 1 cycle.
- RUN: reset_out all 0, ready 1.
- HOLD:
  - All resets asserted; cnt counts STAGE_DELAY cycles, then go to RELEASE.
  - Lock does not need to re-qualify, because it never dropped.
- Lock loss (locked_s=0 in HOLD, RELEASE or RUN):
  - At that edge: reset_out all 1, ready 0, state WAIT_LOCK, counters cleared.
  - lock_lost_count increments unless it is already 255.
- soft_reset_req in RELEASE or RUN: at that edge, reset_out all 1, ready 0, go to HOLD. It is ignored in HOLD.
- Priority: rst > lock loss > soft_reset_req > normal progression.
- A glitch on locked_s shorter than LOCK_STABLE_CYCLES during WAIT_LOCK restarts qualification; no reset is released.
- Reset bits are never released out of order. Once released, a bit stays 0 until a global re-assert.
- All outputs are registered; no combinational path from any input to any output.

Decomposition:
- Package pll_rst_pkg holds:
  - the state enum (WAIT_LOCK, HOLD, RELEASE, RUN);
  - a function giving the counter width, clog2(max(LOCK_STABLE_CYCLES, STAGE_DELAY)).
- Sub-module bit_sync: parameterized SYNC_STAGES flop chain with reset value 0. Reusable for other async status bits.

Test Plan:
All scenarios use SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, STAGE_DELAY=4, NUM_STAGES=3. T is the first edge that samples pll_locked=1.
- Power-up: rst held 3 cycles with pll_locked=0 → reset_out=3'b111, ready=0, lock_lost_count=0, all held indefinitely.
- Clean lock: pll_locked rises and stays high → reset_out[0] falls at edge T+13, [1] at T+17, [2] at T+21; ready rises at T+22.
- Glitch: pll_locked high for 5 cycles, low for 1, then high → the first release is delayed by the restart (reset_out[0] falls 13 edges after the second rise); lock_lost_count stays 0.
- Lock loss in RUN: drop pll_locked → 2 edges later reset_out=3'b111 and ready=0 on the same edge; lock_lost_count=1; re-lock repeats the clean-lock timing.
- Soft reset in RUN: 1-cycle soft_reset_req → reset_out=3'b111 on the next edge; reset_out[0] falls 8 edges after the request edge; ready rises 17 edges after it.
- Simultaneous events and saturation: soft_reset_req on the same edge locked_s drops → WAIT_LOCK, not HOLD. Forcing 260 loss events → lock_lost_count stays at 255.
